uinst_executor: RTL and testbench

- Consumer end of the microinstruction interface: takes 34-bit microinstructions from the MIR decode stages and carries out the bus transfers they describe.
- Buffers incoming microinstructions in a 2-entry FIFO, then sequences each one through operand read, ALU/shift, optional memory access and bus-C write-back.
- Sits between the MIR stages and the register file / ALU / data-memory ports of the ev22 datapath.

---
 rtl/uinst_executor_pkg.sv | 54 +++++
 rtl/uinst_executor_fifo.sv | 70 +++++++
 rtl/uinst_executor.sv | 222 ++++++++++++++++++++++
 tb/tb_uinst_executor.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uinst_executor_pkg.sv
// Shared definitions for the ev22 microinstruction executor: field layout,
// memory-op encodings and sequencer state encodings.
package uinst_executor_pkg;

   localparam int UIN_W     = 34;
   localparam int iT_HI     = 33;
   localparam int iT_LO     = 27;
   localparam int iBUSC_HI  = 26;
   localparam int iBUSC_LO  = 21;
   localparam int iBUSB_HI  = 20;
   localparam int iBUSB_LO  = 15;
   localparam int iSH_HI    = 14;
   localparam int iSH_LO    = 13;
   localparam int iALUC_HI  = 12;
   localparam int iALUC_LO  = 9;
   localparam int iM_HI     = 8;
   localparam int iM_LO     = 7;
   localparam int iKMX      = 6;
   localparam int iBUSA_HI  = 5;
   localparam int iBUSA_LO  = 0;

   typedef enum logic [1:0] {
      M_NONE = 2'b00,
      M_RD   = 2'b01,
      M_WR   = 2'b10,
      M_RSV  = 2'b11
   } mcode_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_EXEC = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4
   } state_t;

   // Packed view of a microinstruction; member order mirrors the bit positions above.
   typedef struct packed {
      logic [iT_HI-iT_LO:0]       t;
      logic [iBUSC_HI-iBUSC_LO:0] busc;
      logic [iBUSB_HI-iBUSB_LO:0] busb;
      logic [iSH_HI-iSH_LO:0]     sh;
      logic [iALUC_HI-iALUC_LO:0] aluc;
      mcode_t                     m;
      logic                       kmx;
      logic [iBUSA_HI-iBUSA_LO:0] busa;
   } uinst_t;

   // The reserved code 11 behaves like a register-only operation.
   function automatic logic needs_mem(input mcode_t m);
      return (m == M_RD) || (m == M_WR);
   endfunction

endpackage

// File: rtl/uinst_executor_fifo.sv
// Show-ahead synchronous FIFO with registered ready; buffers microinstructions
// ahead of the sequencer.
module uinst_fifo #(
   parameter int W     = 50,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     ready,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_next_s;
   logic          ready_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign do_push_s = push && ready_r;
   assign do_pop_s  = pop && (count_r != CW'(0));

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_next_s = count_r;
      if (do_push_s && !do_pop_s) begin
         count_next_s = count_r + CW'(1);
      end else if (!do_push_s && do_pop_s) begin
         count_next_s = count_r - CW'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // Pointers, occupancy and ready; ready stays low while reset is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r  <= AW'(0);
         rptr_r  <= AW'(0);
         count_r <= CW'(0);
         ready_r <= 1'b0;
      end else begin
         if (do_push_s) wptr_r <= wptr_r + AW'(1);
         if (do_pop_s)  rptr_r <= rptr_r + AW'(1);
         count_r <= count_next_s;
         ready_r <= (count_next_s != CW'(DEPTH));
      end
   end

   // Entry storage; contents are meaningless while the pointers say empty.
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wptr_r] <= din;
   end

   assign dout  = mem_r[rptr_r];
   assign ready = ready_r;
   assign empty = (count_r == CW'(0));
   assign count = count_r;

endmodule

// File: rtl/uinst_executor.sv
// Microinstruction executor: FIFO-buffered sequencer driving register file, ALU and memory.
// Optional UEXEC_PERF_EN adds saturating retire and memory-stall counters.
module uinst_executor
   import uinst_executor_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [UIN_W-1:0]  uin,
   input  logic [DATA_W-1:0] uin_k,
   input  logic              uin_valid,
   output logic              uin_ready,
   output logic [5:0]        rf_ra,
   output logic [5:0]        rf_rb,
   input  logic [DATA_W-1:0] rf_da,
   input  logic [DATA_W-1:0] rf_db,
   output logic [3:0]        alu_op,
   output logic [1:0]        alu_sh,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_y,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              rf_we,
   output logic [5:0]        rf_wc,
   output logic [DATA_W-1:0] rf_dc,
   output logic              retire,
   output logic              busy
`ifdef UEXEC_PERF_EN
   ,
   output logic [31:0]       perf_retired,
   output logic [31:0]       perf_stall
`endif
);

   localparam int FW = UIN_W + DATA_W;

   logic [FW-1:0]               fifo_dout_s;
   logic                        fifo_ready_s;
   logic                        fifo_empty_s;
   logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
   logic                        pop_s;
   uinst_t                      head_s;
   logic [DATA_W-1:0]           head_k_s;
   logic                        unused_t_s;

   state_t            state_r;
   uinst_t            cur_r;
   logic [DATA_W-1:0] k_r;
   logic [DATA_W-1:0] result_r;
   logic [5:0]        rf_ra_r;
   logic [5:0]        rf_rb_r;
   logic [3:0]        alu_op_r;
   logic [1:0]        alu_sh_r;
   logic [DATA_W-1:0] alu_a_r;
   logic [DATA_W-1:0] alu_b_r;
   logic              mem_req_r;
   logic              mem_we_r;
   logic [DATA_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              rf_we_r;
   logic [5:0]        rf_wc_r;
   logic [DATA_W-1:0] rf_dc_r;
   logic              retire_r;

   uinst_fifo #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (uin_valid),
      .din   ({uin_k, uin}),
      .pop   (pop_s),
      .dout  (fifo_dout_s),
      .ready (fifo_ready_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   assign head_s     = uinst_t'(fifo_dout_s[UIN_W-1:0]);
   assign head_k_s   = fifo_dout_s[FW-1:UIN_W];
   assign pop_s      = !fifo_empty_s && ((state_r == ST_IDLE) || (state_r == ST_WB));
   assign unused_t_s = ^cur_r.t;

   // Sequencer; each state's outputs are registered on the edge that enters it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cur_r       <= uinst_t'(UIN_W'(0));
         k_r         <= DATA_W'(0);
         result_r    <= DATA_W'(0);
         rf_ra_r     <= 6'd0;
         rf_rb_r     <= 6'd0;
         alu_op_r    <= 4'd0;
         alu_sh_r    <= 2'd0;
         alu_a_r     <= DATA_W'(0);
         alu_b_r     <= DATA_W'(0);
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= DATA_W'(0);
         mem_wdata_r <= DATA_W'(0);
         rf_we_r     <= 1'b0;
         rf_wc_r     <= 6'd0;
         rf_dc_r     <= DATA_W'(0);
         retire_r    <= 1'b0;
      end else begin
         rf_ra_r     <= 6'd0;
         rf_rb_r     <= 6'd0;
         alu_op_r    <= 4'd0;
         alu_sh_r    <= 2'd0;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= DATA_W'(0);
         mem_wdata_r <= DATA_W'(0);
         rf_we_r     <= 1'b0;
         rf_wc_r     <= 6'd0;
         rf_dc_r     <= DATA_W'(0);
         retire_r    <= 1'b0;
         case (state_r)
            ST_IDLE, ST_WB: begin
               if (pop_s) begin
                  cur_r   <= head_s;
                  k_r     <= head_k_s;
                  rf_ra_r <= head_s.busa;
                  rf_rb_r <= head_s.busb;
                  state_r <= ST_READ;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_READ: begin
               alu_a_r  <= cur_r.kmx ? k_r : rf_da;
               alu_b_r  <= rf_db;
               alu_op_r <= cur_r.aluc;
               alu_sh_r <= cur_r.sh;
               state_r  <= ST_EXEC;
            end
            ST_EXEC: begin
               result_r <= alu_y;
               if (needs_mem(cur_r.m)) begin
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= (cur_r.m == M_WR);
                  mem_addr_r  <= alu_a_r;
                  mem_wdata_r <= alu_b_r;
                  state_r     <= ST_MEM;
               end else begin
                  rf_we_r  <= (cur_r.busc != 6'd0);
                  rf_wc_r  <= cur_r.busc;
                  rf_dc_r  <= alu_y;
                  retire_r <= 1'b1;
                  state_r  <= ST_WB;
               end
            end
            ST_MEM: begin
               if (mem_ack) begin
                  if (!mem_we_r) result_r <= mem_rdata;
                  rf_we_r  <= (cur_r.busc != 6'd0);
                  rf_wc_r  <= cur_r.busc;
                  rf_dc_r  <= mem_we_r ? result_r : mem_rdata;
                  retire_r <= 1'b1;
                  state_r  <= ST_WB;
               end else begin
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= mem_we_r;
                  mem_addr_r  <= mem_addr_r;
                  mem_wdata_r <= mem_wdata_r;
                  state_r     <= ST_MEM;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign uin_ready = fifo_ready_s;
   assign rf_ra     = rf_ra_r;
   assign rf_rb     = rf_rb_r;
   assign alu_op    = alu_op_r;
   assign alu_sh    = alu_sh_r;
   assign alu_a     = alu_a_r;
   assign alu_b     = alu_b_r;
   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign rf_we     = rf_we_r;
   assign rf_wc     = rf_wc_r;
   assign rf_dc     = rf_dc_r;
   assign retire    = retire_r;
   assign busy      = (state_r != ST_IDLE) || (fifo_count_s != '0);

`ifdef UEXEC_PERF_EN
   logic [31:0] perf_retired_r;
   logic [31:0] perf_stall_r;

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_retired_r <= 32'd0;
         perf_stall_r   <= 32'd0;
      end else begin
         if (retire_r && (perf_retired_r != 32'hFFFF_FFFF)) begin
            perf_retired_r <= perf_retired_r + 32'd1;
         end
         if ((state_r == ST_MEM) && !mem_ack && (perf_stall_r != 32'hFFFF_FFFF)) begin
            perf_stall_r <= perf_stall_r + 32'd1;
         end
      end
   end

   assign perf_retired = perf_retired_r;
   assign perf_stall   = perf_stall_r;
`endif

endmodule

// File: tb/tb_uinst_executor.sv
// Scoreboard bench for uinst_executor: directed scenarios plus randomized batches
// against a transaction-level reference model.
module tb_uinst_executor;

   typedef struct packed {
      logic        we;
      logic [5:0]  wc;
      logic [15:0] dc;
   } wb_t;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } memop_t;

   logic        clk;
   logic        rst_n;
   logic [33:0] uin;
   logic [15:0] uin_k;
   logic        uin_valid;
   logic        uin_ready;
   logic [5:0]  rf_ra, rf_rb, rf_wc;
   logic [15:0] rf_da, rf_db, alu_a, alu_b, alu_y;
   logic [3:0]  alu_op;
   logic [1:0]  alu_sh;
   logic        mem_req, mem_we, mem_ack, rf_we, retire, busy;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, rf_dc;
`ifdef UEXEC_PERF_EN
   logic [31:0] perf_retired, perf_stall;
`endif

   logic [15:0] rf [64];
   wb_t         wb_q[$];
   memop_t      mem_q[$];
   int          checks = 0;
   int          errors = 0;
   int          n_pushed = 0;
   int          n_retired = 0;
   int          mem_delay = 0;

   uinst_executor #(.DATA_W(16), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .uin(uin), .uin_k(uin_k), .uin_valid(uin_valid),
      .uin_ready(uin_ready), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_da(rf_da), .rf_db(rf_db),
      .alu_op(alu_op), .alu_sh(alu_sh), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rf_we(rf_we), .rf_wc(rf_wc),
      .rf_dc(rf_dc), .retire(retire), .busy(busy)
`ifdef UEXEC_PERF_EN
      , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
   );

   function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [1:0] sh,
                                         input logic [15:0] a, input logic [15:0] b);
      logic [15:0] r;
      case (op)
         4'd0: r = a + b;
         4'd1: r = a - b;
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~a;
         4'd6: r = a;
         4'd7: r = b;
         default: r = a + b + 16'd1;
      endcase
      case (sh)
         2'd1: r = r << 1;
         2'd2: r = r >> 1;
         2'd3: r = {r[14:0], r[15]};
         default: r = r;
      endcase
      return r;
   endfunction

   function automatic logic [15:0] memf(input logic [15:0] addr);
      if (addr == 16'h0100) return 16'hBEEF;
      return addr ^ 16'hA5C3;
   endfunction

   assign rf_da = rf[rf_ra];
   assign rf_db = rf[rf_rb];
   assign alu_y = alu_f(alu_op, alu_sh, alu_a, alu_b);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h required=%0h", name, got, exp);
      end
   endtask

   // Reference model: the architectural effect of one microinstruction.
   task automatic model(input logic [33:0] u, input logic [15:0] k);
      logic [15:0] a, b, y, dc;
      logic [1:0]  m;
      m  = u[8:7];
      a  = u[6] ? k : rf[u[5:0]];
      b  = rf[u[20:15]];
      y  = alu_f(u[12:9], u[14:13], a, b);
      dc = y;
      if (m == 2'b01) begin
         mem_q.push_back('{we: 1'b0, addr: a, wdata: b});
         dc = memf(a);
      end else if (m == 2'b10) begin
         mem_q.push_back('{we: 1'b1, addr: a, wdata: b});
      end
      wb_q.push_back('{we: (u[26:21] != 6'd0), wc: u[26:21], dc: dc});
   endtask

   task automatic issue(input logic [33:0] u, input logic [15:0] k);
      int t = 0;
      @(negedge clk);
      while (!uin_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("push_ready_timeout", uin_ready, 1'b1);
      if (uin_ready) begin
         model(u, k);
         uin = u;
         uin_k = k;
         uin_valid = 1'b1;
         @(posedge clk);
         #1 uin_valid = 1'b0;
         n_pushed++;
      end
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      while ((busy || wb_q.size() != 0 || mem_q.size() != 0) && t < budget) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_timeout", (t < budget), 1'b1);
   endtask

   // Memory responder: acks after mem_delay wait cycles, single-cycle pulse.
   initial begin
      int cnt = 0;
      mem_ack = 1'b0;
      mem_rdata = 16'h0;
      forever begin
         @(negedge clk);
         if (rst_n && mem_req) begin
            cnt++;
            if (cnt == mem_delay + 1) begin
               mem_ack = 1'b1;
               mem_rdata = memf(mem_addr);
            end else begin
               mem_ack = 1'b0;
            end
         end else begin
            cnt = 0;
            mem_ack = 1'b0;
         end
      end
   end

   // Monitor: compares every write-back and memory request with the scoreboard.
   initial begin
      logic   prev_req = 1'b0;
      wb_t    ew;
      memop_t em;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (retire || rf_we) begin
               if (!retire) begin
                  chk("rf_we_without_retire", rf_we, 1'b0);
               end else if (wb_q.size() == 0) begin
                  chk("unexpected_retire", retire, 1'b0);
               end else begin
                  ew = wb_q.pop_front();
                  n_retired++;
                  chk("writeback", {rf_we, rf_wc, rf_dc}, ew);
               end
            end
            if (mem_req && !prev_req) begin
               if (mem_q.size() == 0) begin
                  chk("unexpected_mem_req", mem_req, 1'b0);
               end else begin
                  em = mem_q.pop_front();
                  chk("mem_request", {mem_we, mem_addr, mem_wdata}, em);
               end
            end
            prev_req = mem_req;
         end else begin
            prev_req = 1'b0;
         end
      end
   end

   initial begin
      int          lat, pulses, reqc, webad;
      logic        found;
      logic [63:0] r64;
      rst_n = 1'b0;
      uin = 34'h0;
      uin_k = 16'h0;
      uin_valid = 1'b0;
      for (int i = 0; i < 64; i++) rf[i] = 16'($urandom);

      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs_zero", {uin_ready, rf_ra, rf_rb, alu_op, alu_sh, alu_a, alu_b,
          mem_req, mem_we, mem_addr, mem_wdata, rf_we, rf_wc, rf_dc, retire, busy}, 128'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_reset", uin_ready, 1'b1);
      chk("idle_not_busy", busy, 1'b0);

      // Register op: latency and single retire pulse
      rf[3] = 16'h0010;
      rf[4] = 16'h0002;
      issue({7'h11, 6'd5, 6'd4, 2'd0, 4'd0, 2'b00, 1'b0, 6'd3}, 16'h0);
      lat = -1;
      pulses = 0;
      for (int n = 1; n <= 6; n++) begin
         @(posedge clk);
         #1;
         if (retire) begin
            pulses++;
            if (lat < 0) begin
               lat = n;
               chk("regop_wb", {rf_we, rf_wc, rf_dc}, {1'b1, 6'd5, 16'h0012});
            end
         end
      end
      chk("regop_latency", lat, 3);
      chk("regop_single_retire", pulses, 1);
      wait_idle(50);

      // KMX constant replaces bus A
      rf[9] = 16'hFFFF;
      issue({7'h0, 6'd10, 6'd4, 2'd0, 4'd6, 2'b00, 1'b1, 6'd9}, 16'h00AB);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("kmx_alu_a", alu_a, 16'h00AB);
      chk("kmx_alu_op", alu_op, 4'd6);
      wait_idle(50);

      // NOP
      issue(34'h0, 16'h0);
      wait_idle(50);

      // Memory read with 4 wait states
      mem_delay = 4;
      rf[7] = 16'h0100;
      issue({7'h0, 6'd12, 6'd2, 2'd0, 4'd6, 2'b01, 1'b0, 6'd7}, 16'h0);
      reqc = 0;
      webad = 0;
      found = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(posedge clk);
         #1;
         if (mem_req) begin
            reqc++;
            if (mem_we) webad++;
         end
         if (retire) begin
            found = 1'b1;
            chk("memrd_dc", rf_dc, 16'hBEEF);
         end
      end
      chk("memrd_retired", found, 1'b1);
      chk("memrd_req_cycles", reqc, 5);
      chk("memrd_we_low", webad, 0);
      wait_idle(50);

      // Backpressure with a slow memory
      mem_delay = 12;
      for (int i = 0; i < 5; i++) begin
         issue({7'(i), 6'(20 + i), 6'(i), 2'd0, 4'd6, 2'b01, 1'b0, 6'(i)}, 16'h0);
         if (i == 2) chk("bp_ready_low", uin_ready, 1'b0);
      end
      wait_idle(400);
      chk("retire_count_directed", n_retired, n_pushed);

      // Reset in the middle of a memory access
      mem_delay = 50;
      for (int i = 0; i < 3; i++) begin
         issue({7'h0, 6'(30 + i), 6'(i), 2'd0, 4'd6, 2'b01, 1'b0, 6'(i)}, 16'h0);
      end
      for (int n = 0; n < 20 && !mem_req; n++) @(posedge clk);
      chk("midrst_in_mem", mem_req, 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_abort", {mem_req, busy, uin_ready, retire, rf_we}, 5'b0);
      wb_q.delete();
      mem_q.delete();
      n_pushed = 0;
      n_retired = 0;
      mem_delay = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      chk("midrst_idle_after", {busy, uin_ready}, 2'b01);

      // Randomized batches
      for (int bt = 0; bt < 6; bt++) begin
         mem_delay = $urandom_range(0, 3);
         for (int i = 0; i < 64; i++) rf[i] = 16'($urandom);
         for (int j = 0; j < 10; j++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r64 = {32'($urandom), 32'($urandom)};
            issue(r64[33:0], 16'($urandom));
         end
         wait_idle(400);
      end
      chk("retire_count_random", n_retired, n_pushed);
      chk("queues_empty", {32'(wb_q.size()), 32'(mem_q.size())}, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
